spi_reg_ctrl: RTL

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_pkg.sv | 17 +
 rtl/spi_reg_ctrl_if.sv | 25 ++
 rtl/spi_cs_sync.sv | 30 +++
 rtl/spi_reg_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register controller.
package spi_reg_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StWrite,
      StDrain,
      StFetch
   } state_e;

   localparam int unsigned AddrWDefault     = 4;
   localparam int unsigned AddrWMax         = 7;
   localparam int unsigned RdFlagBitDefault = 7;
   localparam int unsigned CmdByteW         = 8;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-slave handshake and register-bus signals of the SPI register controller.
interface spi_reg_ctrl_if
   import spi_reg_pkg::*;
#(
   parameter int unsigned ADDR_W = AddrWDefault
);
   logic                data_ready;
   logic [CmdByteW-1:0] received_data;
   logic                read_ack;
   logic [CmdByteW-1:0] data_to_send;
   logic [ADDR_W-1:0]   reg_addr;
   logic [CmdByteW-1:0] reg_wdata;
   logic                reg_we;
   logic [CmdByteW-1:0] reg_rdata;

   modport master (
      input  data_ready, received_data, reg_rdata,
      output read_ack, data_to_send, reg_addr, reg_wdata, reg_we
   );

   modport slave (
      output data_ready, received_data, reg_rdata,
      input  read_ack, data_to_send, reg_addr, reg_wdata, reg_we
   );
endinterface

// File: rtl/spi_cs_sync.sv
// Two-flop synchronizer for the raw SPI chip select, with edge pulses on the synced level.
module spi_cs_sync (
   input  logic system_clk,
   input  logic rst_n,
   input  logic spi_cs,
   output logic cs_sync,
   output logic cs_fall,
   output logic cs_rise
);
   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Flops reset high so CS reads as deselected until it is actually sampled.
   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= spi_cs;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign cs_sync = sync_q;
   assign cs_fall = prev_q & ~sync_q;
   assign cs_rise = ~prev_q & sync_q;
endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command decoder driving a small register bus; reads are two-frame.
// Optional SPI_REG_CTRL_AUTOINC_EN: write bursts and streaming reads.
module spi_reg_ctrl
   import spi_reg_pkg::*;
#(
   parameter int unsigned ADDR_W      = AddrWDefault,
   parameter int unsigned RD_FLAG_BIT = RdFlagBitDefault
) (
   input  logic           system_clk,
   input  logic           rst_n,
   input  logic           spi_cs,
   spi_reg_ctrl_if.master bus,
   output logic           busy
);
   state_e              state_q;
   logic                ack_pending_q;
   logic                read_ack_q;
   logic                reg_we_q;
   logic                fetch_wait_q;
   logic [ADDR_W-1:0]   reg_addr_q;
   logic [CmdByteW-1:0] reg_wdata_q;
   logic [CmdByteW-1:0] data_to_send_q;

   logic                cs_sync;
   logic                cs_fall;
   logic                cs_rise;
   logic                consume;
   logic                frame_end;
   logic                refetch;
   logic [CmdByteW-1:0] rx_byte;
   logic                unused_cs_rise;

   spi_cs_sync u_cs_sync (
      .system_clk (system_clk),
      .rst_n      (rst_n),
      .spi_cs     (spi_cs),
      .cs_sync    (cs_sync),
      .cs_fall    (cs_fall),
      .cs_rise    (cs_rise)
   );

   assign unused_cs_rise = cs_rise;
   assign rx_byte        = bus.received_data;

   assign frame_end = cs_sync && (state_q inside {StCmd, StWrite, StDrain});
   assign consume   = bus.data_ready && !ack_pending_q && !cs_sync &&
                      (state_q inside {StCmd, StWrite, StDrain});

`ifdef SPI_REG_CTRL_AUTOINC_EN
   logic [ADDR_W-1:0] rd_addr_q;
   logic              fetched_q;
   logic              data_frame_q;

   // A frame that follows a completed fetch is a read data frame; unless it
   // issued its own read, its end advances the read address and refetches.
   assign refetch = data_frame_q && !fetched_q;
`else
   assign refetch = 1'b0;
`endif

   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         ack_pending_q  <= 1'b0;
         read_ack_q     <= 1'b0;
         reg_we_q       <= 1'b0;
         fetch_wait_q   <= 1'b0;
         reg_addr_q     <= '0;
         reg_wdata_q    <= '0;
         data_to_send_q <= '0;
`ifdef SPI_REG_CTRL_AUTOINC_EN
         rd_addr_q      <= '0;
         fetched_q      <= 1'b0;
         data_frame_q   <= 1'b0;
`endif
      end else begin
         read_ack_q <= consume;
         reg_we_q   <= 1'b0;
         if (consume) begin
            ack_pending_q <= 1'b1;
         end else if (!bus.data_ready) begin
            ack_pending_q <= 1'b0;
         end
`ifdef SPI_REG_CTRL_AUTOINC_EN
         if (reg_we_q) begin
            reg_addr_q <= reg_addr_q + ADDR_W'(1);
         end
         if (cs_fall) begin
            data_frame_q <= fetched_q;
            fetched_q    <= 1'b0;
         end
`endif
         if (frame_end) begin
            if (refetch) begin
               state_q      <= StFetch;
               fetch_wait_q <= 1'b0;
`ifdef SPI_REG_CTRL_AUTOINC_EN
               reg_addr_q   <= rd_addr_q + ADDR_W'(1);
               data_frame_q <= 1'b0;
`endif
            end else begin
               state_q <= StIdle;
            end
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (cs_fall) state_q <= StCmd;
               end
               StCmd: begin
                  if (consume) begin
                     reg_addr_q   <= rx_byte[ADDR_W-1:0];
                     fetch_wait_q <= 1'b0;
                     state_q      <= rx_byte[RD_FLAG_BIT] ? StFetch : StWrite;
                  end
               end
               StWrite: begin
                  if (consume) begin
                     reg_wdata_q <= rx_byte;
                     reg_we_q    <= 1'b1;
`ifndef SPI_REG_CTRL_AUTOINC_EN
                     state_q     <= StDrain;
`endif
                  end
               end
               StDrain: begin
                  state_q <= StDrain;
               end
               StFetch: begin
                  // reg_rdata trails reg_addr by a cycle, so capture on the second cycle.
                  if (!fetch_wait_q) begin
                     fetch_wait_q <= 1'b1;
                  end else begin
                     fetch_wait_q   <= 1'b0;
                     data_to_send_q <= bus.reg_rdata;
                     state_q        <= cs_sync ? StIdle : StDrain;
`ifdef SPI_REG_CTRL_AUTOINC_EN
                     rd_addr_q      <= reg_addr_q;
                     fetched_q      <= 1'b1;
`endif
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus.read_ack     = read_ack_q;
   assign bus.reg_we       = reg_we_q;
   assign bus.reg_addr     = reg_addr_q;
   assign bus.reg_wdata    = reg_wdata_q;
   assign bus.data_to_send = data_to_send_q;
   assign busy             = (state_q != StIdle);
endmodule
